// File: rtl/m_button_debouncer_pkg.sv
// Shared types and constants for the pushbutton debouncer.
package pkg_button_debouncer;

    localparam int C_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        S_RELEASED,
        S_PRESS_WAIT,
        S_PRESSED,
        S_RELEASE_WAIT
    } t_db_state;

endpackage

// File: rtl/m_button_debouncer_if.sv
// Button-side signal bundle: raw input in, debounced level and event pulses out.
interface m_button_debouncer_if;

    logic btn_in;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic repeat_pulse;
    logic count_en;

    modport master (
        output btn_in,
        input  btn_level, press_pulse, release_pulse, repeat_pulse, count_en
    );

    modport slave (
        input  btn_in,
        output btn_level, press_pulse, release_pulse, repeat_pulse, count_en
    );

endinterface

// File: rtl/m_button_debouncer_synchronizer.sv
// N-flop single-bit synchronizer for an asynchronous input.
module m_synchronizer
    import pkg_button_debouncer::*;
#(
    parameter int P_STAGES = C_SYNC_STAGES
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic [P_STAGES-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (i_reset) r_sync <= '0;
        else         r_sync <= {r_sync[P_STAGES-2:0], i_d};
    end

    assign o_q = r_sync[P_STAGES-1];

endmodule

// File: rtl/m_button_debouncer.sv
// Pushbutton debouncer: stable-count FSM with press/release pulses and
// optional auto-repeat while held; all outputs registered.
module m_button_debouncer
    import pkg_button_debouncer::*;
#(
    parameter int P_STABLE_CYCLES = 500000,
    parameter int P_REPEAT_EN     = 1,
    parameter int P_REPEAT_DELAY  = 25000000,
    parameter int P_REPEAT_PERIOD = 5000000
) (
    input  logic           i_clk,
    input  logic           i_reset,
    m_button_debouncer_if.slave bus
);

    localparam int C_STB_W   = $clog2(P_STABLE_CYCLES) + 1;
    localparam int C_REP_MAX = (P_REPEAT_DELAY > P_REPEAT_PERIOD) ? P_REPEAT_DELAY : P_REPEAT_PERIOD;
    localparam int C_REP_W   = $clog2(C_REP_MAX) + 1;

    localparam logic [C_STB_W-1:0] C_STB_LAST   = C_STB_W'(P_STABLE_CYCLES - 1);
    localparam logic [C_REP_W-1:0] C_DELAY_LAST = C_REP_W'(P_REPEAT_DELAY - 1);
    localparam logic [C_REP_W-1:0] C_PER_LAST   = C_REP_W'(P_REPEAT_PERIOD - 1);

    t_db_state            r_state;
    logic [C_STB_W-1:0]   r_stb_cnt;
    logic [C_REP_W-1:0]   r_rep_cnt;
    logic                 r_rep_armed;
    logic                 r_level;
    logic                 r_press;
    logic                 r_release;
    logic                 r_repeat;
    logic                 r_count_en;

    logic                 w_btn_sync;
    logic                 w_stb_done;
    logic                 w_rep_hit;

    m_synchronizer #(.P_STAGES(C_SYNC_STAGES)) u_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (bus.btn_in),
        .o_q     (w_btn_sync)
    );

    // The sample that reaches the threshold is the accepting one, so the
    // wait states compare against P_STABLE_CYCLES-1 before incrementing.
    assign w_stb_done = (r_stb_cnt >= C_STB_LAST);

    // First repeat uses the initial delay, later ones the period.
    assign w_rep_hit = (P_REPEAT_EN != 0) && (r_state == S_PRESSED) &&
                       (r_rep_cnt == (r_rep_armed ? C_PER_LAST : C_DELAY_LAST));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_RELEASED;
            r_stb_cnt   <= '0;
            r_rep_cnt   <= '0;
            r_rep_armed <= 1'b0;
            r_level     <= 1'b0;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
            r_repeat    <= 1'b0;
            r_count_en  <= 1'b0;
        end else begin
            r_press    <= 1'b0;
            r_release  <= 1'b0;
            r_repeat   <= 1'b0;
            r_count_en <= 1'b0;
            case (r_state)
                S_RELEASED: begin
                    r_rep_cnt   <= '0;
                    r_rep_armed <= 1'b0;
                    if (w_btn_sync) begin
                        r_state   <= S_PRESS_WAIT;
                        r_stb_cnt <= C_STB_W'(1);
                    end
                end
                S_PRESS_WAIT: begin
                    if (!w_btn_sync) begin
                        r_state   <= S_RELEASED;
                        r_stb_cnt <= '0;
                    end else if (w_stb_done) begin
                        r_state     <= S_PRESSED;
                        r_stb_cnt   <= '0;
                        r_level     <= 1'b1;
                        r_press     <= 1'b1;
                        r_count_en  <= 1'b1;
                        r_rep_cnt   <= '0;
                        r_rep_armed <= 1'b0;
                    end else begin
                        r_stb_cnt <= r_stb_cnt + 1'b1;
                    end
                end
                S_PRESSED: begin
                    if (w_rep_hit) begin
                        r_rep_cnt   <= '0;
                        r_rep_armed <= 1'b1;
                        r_repeat    <= 1'b1;
                        r_count_en  <= 1'b1;
                    end else if (r_rep_cnt != '1) begin
                        r_rep_cnt <= r_rep_cnt + 1'b1;
                    end
                    if (!w_btn_sync) begin
                        r_state   <= S_RELEASE_WAIT;
                        r_stb_cnt <= C_STB_W'(1);
                    end
                end
                S_RELEASE_WAIT: begin
                    // Repeat timer intentionally frozen here so a short
                    // release glitch does not disturb the repeat cadence.
                    if (w_btn_sync) begin
                        r_state   <= S_PRESSED;
                        r_stb_cnt <= '0;
                    end else if (w_stb_done) begin
                        r_state   <= S_RELEASED;
                        r_stb_cnt <= '0;
                        r_level   <= 1'b0;
                        r_release <= 1'b1;
                    end else begin
                        r_stb_cnt <= r_stb_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_RELEASED;
                    r_stb_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.btn_level     = r_level;
    assign bus.press_pulse   = r_press;
    assign bus.release_pulse = r_release;
    assign bus.repeat_pulse  = r_repeat;
    assign bus.count_en      = r_count_en;

endmodule

// File: doc/m_button_debouncer.md
M_BUTTON_DEBOUNCER -- requirements
Module: m_button_debouncer

Interface
REQ-001 Parameter P_STABLE_CYCLES, default 500000: consecutive synchronized cycles of a steady level that are needed to accept a level change; legal range >= 2.
REQ-002 Parameter P_REPEAT_EN, default 1: 1 enables auto-repeat while the button is held; 0 disables it.
REQ-003 Parameter P_REPEAT_DELAY, default 25000000: cycles from press_pulse to the first repeat_pulse; legal range >= 1.
REQ-004 Parameter P_REPEAT_PERIOD, default 5000000: cycles between successive repeat_pulse; legal range >= 1.
REQ-005 clk  input  1  single clock; all logic on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 btn_in  input  1  raw, asynchronous, bouncing pushbutton; 1 = pressed.
REQ-008 btn_level  output  1  debounced button level.
REQ-009 press_pulse  output  1  one-cycle pulse when a press is accepted.
REQ-010 release_pulse  output  1  one-cycle pulse when a release is accepted.
REQ-011 repeat_pulse  output  1  one-cycle pulse for each auto-repeat tick.
REQ-012 count_en  output  1  press_pulse OR repeat_pulse; this is the count enable for the downstream counter.

Function
REQ-013 btn_in shall pass through a 2-flop synchronizer; its output is btn_sync, and all other logic shall use btn_sync only.
REQ-014 The FSM shall have four states: S_RELEASED, S_PRESS_WAIT, S_PRESSED, S_RELEASE_WAIT.
REQ-015 S_RELEASED: btn_sync=1 -> go to S_PRESS_WAIT with stable counter = 1.
REQ-016 S_PRESS_WAIT: btn_sync=1 -> increment the stable counter; at P_STABLE_CYCLES -> go to S_PRESSED. btn_sync=0 -> go to S_RELEASED and clear the counter.
REQ-017 S_PRESSED: btn_sync=0 -> go to S_RELEASE_WAIT with stable counter = 1.
REQ-018 S_RELEASE_WAIT: btn_sync=0 -> increment the stable counter; at P_STABLE_CYCLES -> go to S_RELEASED. btn_sync=1 -> go to S_PRESSED, with no press_pulse.
REQ-019 btn_level shall be 1 exactly in S_PRESSED and S_RELEASE_WAIT.
REQ-020 All outputs shall be registered; pulses are high for exactly one cycle, in the cycle after the accepting transition.
REQ-021 Latency: if btn_in rises before sampling edge k and stays steady, press_pulse shall be high in the cycle following edge k+1+P_STABLE_CYCLES. Release latency is the same, applied to release_pulse.
REQ-022 Any low or high excursion shorter than P_STABLE_CYCLES synchronized cycles shall produce no pulse and no btn_level change.
REQ-023 Repeat timer: cleared when press_pulse is issued; increments each cycle in S_PRESSED; holds (no increment, no clear) in S_RELEASE_WAIT; cleared in S_RELEASED.
REQ-024 When P_REPEAT_EN=1: repeat_pulse at P_REPEAT_DELAY cycles after press_pulse, then every P_REPEAT_PERIOD cycles while in S_PRESSED.
REQ-025 When P_REPEAT_EN=0: repeat_pulse shall be constant 0.
REQ-026 press_pulse and repeat_pulse shall never be high in the same cycle; count_en shall therefore be a single-cycle pulse per event.
REQ-027 Counter widths shall be $clog2 of the largest compared value plus 1; counters saturate and never wrap.

Reset
REQ-028 While reset=1 at an edge: state = S_RELEASED, synchronizer flops = 0, all counters = 0, all outputs = 0.
REQ-029 Reset asserted mid-operation (any state) shall abort it with no pulse in the following cycle.
REQ-030 A button held across reset deassertion shall be debounced as a new press, giving press_pulse at the normal latency.

Structure
REQ-031 Package pkg_button_debouncer shall hold the state enum typedef (t_db_state) and the synchronizer depth constant C_SYNC_STAGES = 2.
REQ-032 The synchronizer shall be the sub-module m_synchronizer (parameterized depth, 1-bit), instantiated once.

Verification (bench parameters: P_STABLE_CYCLES=4, P_REPEAT_DELAY=20, P_REPEAT_PERIOD=8)
REQ-033 Clean press held 12 cycles -> press_pulse exactly once, 6 cycles after the first edge with btn_in=1; btn_level=1 from that cycle on.
REQ-034 Bounce: btn_in = 1,0,1,1,0,1,1,1,0 (one value per cycle) -> zero pulses, btn_level stays 0.
REQ-035 Press, then release held 10 cycles -> release_pulse exactly once, 6 cycles after the falling sample; btn_level=0 from then on; a 2-cycle low glitch while pressed produces no pulse.
REQ-036 Hold 60 cycles with P_REPEAT_EN=1 -> count_en high at cycles 6, 26, 34, 42, 50, 58; with P_REPEAT_EN=0 -> high only at cycle 6.
REQ-037 Reset pulsed during S_PRESS_WAIT with btn_in held -> all outputs 0 the next cycle; press_pulse 6 cycles after reset deasserts.
